// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: data stage has fixed priority over fetch.
// Optional access timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

    state_t state;
    logic   own_dm;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [3:0] cnt;
`else
    assign err = 1'b0;
`endif

    // Word alignment drops the byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    assign stall = ((dm_read | dm_write) & ~dm_ready) | (if_req & ~if_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            own_dm    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_data   <= '0;
            dm_rdata  <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (dm_read | dm_write) begin
                        state     <= DATA;
                        own_dm    <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= {dm_addr[31:2], 2'b00};
                        mem_wdata <= dm_wdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end else if (if_req) begin
                        state    <= FETCH;
                        own_dm   <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {if_addr[31:2], 2'b00};
`ifdef MEM_ARBITER_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                DATA, FETCH: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (own_dm) begin
                            dm_ready <= 1'b1;
                            if (!mem_we) dm_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_data  <= mem_rdata;
                        end
`ifdef MEM_ARBITER_TIMEOUT_EN
                    end else if (cnt == 4'd14) begin
                        // This busy cycle brings the count to 15: give up.
                        cnt     <= cnt + 4'd1;
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        if (own_dm) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_data  <= '0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
                    err      <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-schedule model.
// Each grant is scheduled arithmetically: req window, ready cycle, idle cycle.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_data(if_data),
        .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .err(err)
    );

    always #5 clock = ~clock;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mem [64];

    // transaction schedule
    bit          busy, own_dm, wr, to;
    int          g, a;
    logic [31:0] laddr, lwdata, cap;

    // requesters
    bit          dm_pend, if_pend, dm_fin, if_fin, dm_r, dm_w;
    logic [31:0] dm_a, dm_wd, if_a;
    logic [31:0] exp_if_data, exp_dm_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        busy = 0; dm_pend = 0; if_pend = 0; dm_fin = 0; if_fin = 0;
        exp_if_data = '0; exp_dm_rdata = '0;
        if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_ready"}, if_ready, 0);
        chk({tag, "_dm_ready"}, dm_ready, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_if_data"}, if_data, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    // Assert reset mid-cycle, without waiting for an edge.
    task automatic rst_pulse();
        @(negedge clock);
        cyc++;
        model_clear();
        reset = 1'b1;
        #1;
        reset_checks("rst");
        @(negedge clock);
        cyc++;
        reset = 1'b0;
    endtask

    task automatic step();
        int unsigned r;
        int unsigned d;
        logic [31:0] sel;
        bit exp_req, rdy, ack;
        logic [31:0] rd;
        @(negedge clock);
        cyc++;
        if (dm_fin) begin dm_pend = 0; dm_fin = 0; end
        if (if_fin) begin if_pend = 0; if_fin = 0; end
        if (busy && cyc >= a + 2) busy = 0;
        if (!dm_pend && $urandom_range(2) == 0) begin
            dm_pend = 1;
            r = $urandom_range(2);
            dm_r = (r != 1);
            dm_w = (r != 0);
            dm_a = $urandom;
            dm_wd = $urandom;
        end
        if (!if_pend && $urandom_range(2) == 0) begin
            if_pend = 1;
            if_a = $urandom;
        end
        // grant only when the arbiter is idle this cycle
        if (!busy && (dm_pend || if_pend)) begin
            busy = 1;
            g = cyc;
            own_dm = dm_pend;
            wr = dm_pend && dm_w;
            sel = dm_pend ? dm_a : if_a;
            laddr = {sel[31:2], 2'b00};
            lwdata = dm_wd;
            r = $urandom_range(9);
            d = (r <= 5) ? r : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? 20 : 0;
            to = TO_EN && d >= 15;
            a = to ? g + 15 : g + 1 + int'(d);
        end
        exp_req = busy && cyc > g && cyc <= a;
        rdy = busy && cyc == a + 1;
        if (rdy) begin
            if (own_dm) begin
                dm_fin = 1;
                if (to) exp_dm_rdata = '0;
                else if (!wr) exp_dm_rdata = cap;
            end else begin
                if_fin = 1;
                exp_if_data = to ? 32'h0 : cap;
            end
        end
        ack = exp_req && cyc == a && !to;
        rd = $urandom;
        if (ack) begin
            rd = mem[laddr[7:2]];
            cap = rd;
            if (wr) mem[laddr[7:2]] = lwdata;
        end else if (!exp_req && $urandom_range(4) == 0) begin
            ack = 1;
        end
        dm_read = dm_pend & dm_r;
        dm_write = dm_pend & dm_w;
        dm_addr = dm_pend ? dm_a : $urandom;
        dm_wdata = dm_pend ? dm_wd : $urandom;
        if_req = if_pend;
        if_addr = if_pend ? if_a : $urandom;
        mem_ack = ack;
        mem_rdata = rd;
        #1;
        chk("mem_req", mem_req, exp_req);
        if (exp_req) begin
            chk("mem_addr", mem_addr, laddr);
            chk("mem_we", mem_we, wr);
            if (wr) chk("mem_wdata", mem_wdata, lwdata);
        end
        chk("if_ready", if_ready, rdy && !own_dm);
        chk("dm_ready", dm_ready, rdy && own_dm);
        chk("err", err, rdy && to);
        chk("if_data", if_data, exp_if_data);
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        chk("stall", stall, (dm_pend && !(rdy && own_dm)) ||
                            (if_pend && !(rdy && !own_dm)));
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_clear();
        reset = 1'b1;
        #1;
        reset_checks("init");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(299) == 0) rst_pulse();
            else step();
        end

        // reset while a fetch is waiting on memory
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int i = 0; i < 500 && !found; i++) begin
                step();
                found = busy && !own_dm && a > cyc;
            end
            chk("find_fetch", found, 1);
            if (found) begin
                @(negedge clock);
                cyc++;
                chk("pre_rst_req", mem_req, 1);
                model_clear();
                reset = 1'b1;
                #1;
                reset_checks("fetch_rst");
                @(negedge clock);
                cyc++;
                reset = 1'b0;
            end
        end

        for (int i = 0; i < 1500; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch-stage read request; held high until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_ready  out  1  one-cycle pulse: fetch access complete, if_data valid.
REQ-007 if_data  out  32  registered fetch read data.
REQ-008 dm_read  in  1  data-stage load request (control readmem); held until dm_ready.
REQ-009 dm_write  in  1  data-stage store request (control writemem); held until dm_ready.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  store data.
REQ-012 dm_ready  out  1  one-cycle pulse: data access complete, dm_rdata valid for loads.
REQ-013 dm_rdata  out  32  registered load data.
REQ-014 mem_req  out  1  request to the shared single-port memory.
REQ-015 mem_we  out  1  write enable to memory, valid while mem_req is high.
REQ-016 mem_addr  out  32  latched word address, with bits [1:0] forced to 0.
REQ-017 mem_wdata  out  32  latched store data.
REQ-018 mem_ack  in  1  memory completion, sampled on the rising edge.
REQ-019 mem_rdata  in  32  memory read data, valid in the same cycle as mem_ack.
REQ-020 stall  out  1  pipeline freeze, combinational.
REQ-021 err  out  1  one-cycle timeout pulse concurrent with ready.

Function
REQ-022 FSM states SHALL be IDLE, DATA, FETCH, DONE.
REQ-023 In IDLE, the block SHALL grant by fixed priority: data first, then fetch. Grant is dm_read|dm_write -> DATA, else if_req -> FETCH, else stay in IDLE.
REQ-024 On grant, the block SHALL latch the owner, the address, the write data and the write flag; if both dm_write and dm_read are high, the access is a write.
REQ-025 In DATA/FETCH, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be held stable until mem_ack.
REQ-026 On a rising edge with mem_ack=1 in DATA/FETCH, the block SHALL capture mem_rdata into the owner's data register (unchanged on a write) and go to DONE.
REQ-027 DONE SHALL last exactly one cycle: the owner's ready is 1, mem_req is 0, and the next state is IDLE unconditionally.
REQ-028 A request seen during DONE SHALL NOT be granted until the following IDLE cycle.
REQ-029 Latency: request high in IDLE at cycle 0 -> mem_req at cycle 1 -> ack at cycle k>=1 -> ready at cycle k+1 -> IDLE at cycle k+2.
REQ-030 stall SHALL equal ((dm_read|dm_write) & ~dm_ready) | (if_req & ~if_ready).
REQ-031 mem_ack outside DATA/FETCH SHALL be ignored.
REQ-032 if_data and dm_rdata SHALL hold their values between completions.
REQ-033 A fetch in progress SHALL NOT be preempted by a later data request; the data request is granted at the next IDLE.

Reset
REQ-034 When reset is asserted, the block SHALL immediately set: state=IDLE; mem_req, mem_we, if_ready, dm_ready, err = 0; mem_addr, mem_wdata, if_data, dm_rdata = 0; timeout counter = 0.
REQ-035 Reset during DATA/FETCH SHALL abandon the access with no ready pulse, and mem_req SHALL drop without waiting for a clock.

Configuration
REQ-036 The macro MEM_ARBITER_TIMEOUT_EN SHALL control the access timeout.
REQ-037 With MEM_ARBITER_TIMEOUT_EN defined: a 4-bit counter clears on grant and increments each DATA/FETCH cycle without mem_ack. When the counter reaches 15 without ack, the block goes to DONE with ready=1, err=1 and the owner's data register cleared to 0.
REQ-038 Without MEM_ARBITER_TIMEOUT_EN: no counter exists, err is tied to 0, and the block waits indefinitely for mem_ack.

Verification
REQ-039 if_req=1, if_addr=0x0000_0043, mem_ack on cycle 1 with rdata=0x2008_0005 -> mem_addr=0x40; if_ready pulses at cycle 2; if_data=0x2008_0005; stall falls at cycle 2.
REQ-040 if_req and dm_read both asserted in IDLE, dm_addr=0x100, ack one cycle after each mem_req -> data served first (dm_ready at cycle 2), then fetch (if_ready at cycle 5).
REQ-041 dm_write=dm_read=1, dm_wdata=0xDEAD_BEEF, ack delayed 3 cycles -> mem_we=1 and mem_wdata stable for 3 cycles; dm_ready at cycle 4; dm_rdata unchanged.
REQ-042 Reset asserted mid-access in FETCH -> mem_req goes to 0 before the next edge; after release, no if_ready pulse until if_req is granted anew.
REQ-043 With MEM_ARBITER_TIMEOUT_EN, dm_read held with mem_ack never asserted -> after 15 busy cycles, dm_ready=1, err=1, dm_rdata=0; without the macro, stall remains 1 indefinitely.
REQ-044 A spurious mem_ack in IDLE -> no ready pulse and no data register change.
